vga_sprite_scheduler: RTL and testbench
=======================================

# vga_sprite_scheduler

Per-frame motion controller for the two VGA boxes drawn by the pixel generator. It detects the start of each frame from `v_sync` and snapshots the push-buttons and switches. It then runs a small state machine that updates box 0 and box 1 on consecutive clocks, and presents clamped, registered positions to the pixel generator. It replaces direct `v_sync`-clocked position logic with a single-clock, synchronous design.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `BOX_W0` / `BOX_H0`, 40 / 40: box 0 size.
- `BOX_W1` / `BOX_H1`, 40 / 40: box 1 size.
- `SLOW_STEP`, 2: pixels per frame, slow speed.
- `FAST_STEP`, 6: pixels per frame, fast speed.
- `clk  in  1`: pixel clock; the only clock.
- `rst  in  1`: synchronous, active-low reset.
- `v_sync  in  1`: vertical sync from the timing generator. Asynchronous to the logic and treated as such.
- `KEY  in  4`: active-low buttons. Each bit means "pressed" when 0:
  - KEY[0]: +x.
  - KEY[3]: −x.
  - KEY[1]: +y.
  - KEY[2]: −y.
- `SW  in  10`: switches.
  - SW[1]: move enable, box 0.
  - SW[2]: move enable, box 1.
  - SW[9]: fast speed.
  - Other bits are ignored.
- `xpos_0`, `ypos_0`  out  11 each: box 0 top-left corner.
- `xpos_1`, `ypos_1`  out  11 each: box 1 top-left corner.
- `busy  out  1`: high while an update sequence is in progress.
- `frame_done  out  1`: one-cycle pulse when both boxes have been updated.
- `overrun  out  1`: sticky. Set when a frame start arrives while `busy` is high.

## Operation
- **Input synchronisation:** `v_sync` and `KEY` each pass through a 2-flop synchronizer. Frame start (`fs`) = synchronised `v_sync` is 1 and its registered previous value is 0 (rising edge).
- **Snapshot:** on `fs` in IDLE, the synchronised `KEY` and SW[9:1] are latched. All moves in that frame use the snapshot.
- **FSM states:**
  - IDLE → UPD0 on `fs`.
  - UPD0 → UPD1 unconditionally.
  - UPD1 → DONE unconditionally.
  - DONE → IDLE unconditionally.
- **Position writes:**
  - Box 0 x/y are written at the clock edge leaving UPD0.
  - Box 1 x/y are written at the clock edge leaving UPD1.
  - A box's position changes only if its enable bit (SW[1] or SW[2]) is set in the snapshot.
- **Step size:** `FAST_STEP` if snapshot SW[9]=1, else `SLOW_STEP`.
- **Per-axis move rule:**
  - Exactly one of the axis's two keys pressed: move in that direction.
  - Neither or both pressed: no change on that axis.
- **Arithmetic and clamping:**
  - Computed at 12 bits to avoid wrap.
  - +x: new = min(x + step, `H_ACTIVE` − W).
  - −x: new = (x < step) ? 0 : x − step.
  - y uses the same rules with `V_ACTIVE` − H.
  - Positions never leave [0, ACTIVE − size]. There is no wrap-around.
- **Status outputs:**
  - `busy` = state ≠ IDLE.
  - `frame_done` = (state == DONE).
  - `overrun` is set on `fs` in any non-IDLE state; that `fs` is ignored. It is cleared only by reset.
- **Reset values:**
  - `xpos_0` = 0, `ypos_0` = 0.
  - `xpos_1` = `H_ACTIVE` − `BOX_W1`, `ypos_1` = `V_ACTIVE` − `BOX_H1`.
  - `busy` = 0, `frame_done` = 0, `overrun` = 0.
  - State = IDLE; synchronizers and snapshot cleared to the idle levels (`v_sync` 0, `KEY` 1).
- **Reset mid-sequence:** all of the above are restored at that edge. A half-finished frame leaves no partial update.

## Timing
- Let `v_sync` first be sampled high at edge N, with `rst` high and the FSM in IDLE.
  - `fs` is high in the cycle after edge N+1.
  - The FSM enters UPD0 at edge N+2, and the snapshot is taken at edge N+2.
  - Box 0 outputs update at edge N+3.
  - Box 1 outputs update at edge N+4.
  - `frame_done` is high from edge N+4 to edge N+5.
  - `busy` is high from edge N+2 to edge N+5.
- The sequence takes 3 cycles, far shorter than a frame. An `overrun` only occurs with a malformed `v_sync` (sync pulse shorter than the sequence does not matter; only re-rising edges within 3 cycles do).
- A `v_sync` held high produces exactly one `fs`.
- Position outputs are registered and stable outside their write edge. The pixel generator may sample them at any time.

## Test plan
- **Reset:** assert `rst`=0 for 2 cycles.
  - Expect positions (0,0) and (600,440); `busy`=0, `frame_done`=0, `overrun`=0.
- **Slow move, box 0:** SW[1]=1, SW[9]=0, KEY=4'b1110, one `v_sync` rising edge.
  - Expect `xpos_0` 0→2 at N+3.
  - Box 1 unchanged.
  - `frame_done` pulses exactly once, at N+4.
- **Fast move, clamped:** SW[2]=1, SW[9]=1, KEY=4'b1101 (+y), `ypos_1`=440.
  - Expect `ypos_1` stays 440.
  - After two more frames with KEY=4'b1011 (−y), expect 428.
- **Lower clamp:** box 0 at x=4, SW[9]=1, KEY=4'b0111 (−x).
  - Expect `xpos_0`=0, not a wrapped value.
- **Conflicting keys and disabled box:**
  - KEY=4'b0110 (both x keys pressed) with SW[1]=1: expect no x change.
  - SW[1]=0 with any keys: expect box 0 frozen.
- **Overrun and mid-sequence reset:**
  - Pulse `v_sync` twice, 2 cycles apart: expect a single update and `overrun`=1.
  - Assert `rst`=0 at N+3: expect reset values at the next edge and no box 1 update.

Source files
------------

// File: rtl/vga_sprite_scheduler_if.sv
// Bus between the VGA timing/input side and the sprite scheduler:
// sync, buttons and switches in; box positions and status out.
interface vga_sprite_scheduler_if;
    logic        v_sync_i;
    logic [3:0]  key_i;
    logic [9:0]  sw_i;
    logic [10:0] xpos_0_o;
    logic [10:0] ypos_0_o;
    logic [10:0] xpos_1_o;
    logic [10:0] ypos_1_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        overrun_o;

    modport master (
        output v_sync_i, key_i, sw_i,
        input  xpos_0_o, ypos_0_o, xpos_1_o, ypos_1_o,
        input  busy_o, frame_done_o, overrun_o
    );

    modport slave (
        input  v_sync_i, key_i, sw_i,
        output xpos_0_o, ypos_0_o, xpos_1_o, ypos_1_o,
        output busy_o, frame_done_o, overrun_o
    );
endinterface

// File: rtl/vga_sprite_scheduler.sv
// Per-frame motion controller for two VGA boxes: detects frame start on a
// synchronised v_sync, snapshots inputs, then moves box 0 and box 1 on consecutive clocks.
module vga_sprite_scheduler #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BOX_W0    = 40,
    parameter int BOX_H0    = 40,
    parameter int BOX_W1    = 40,
    parameter int BOX_H1    = 40,
    parameter int SLOW_STEP = 2,
    parameter int FAST_STEP = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_sprite_scheduler_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UPD0 = 2'd1;
    localparam logic [1:0] S_UPD1 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [11:0] X_MAX0 = 12'(H_ACTIVE - BOX_W0);
    localparam logic [11:0] Y_MAX0 = 12'(V_ACTIVE - BOX_H0);
    localparam logic [11:0] X_MAX1 = 12'(H_ACTIVE - BOX_W1);
    localparam logic [11:0] Y_MAX1 = 12'(V_ACTIVE - BOX_H1);
    localparam logic [11:0] STEP_S = 12'(SLOW_STEP);
    localparam logic [11:0] STEP_F = 12'(FAST_STEP);

    // One axis: move only when exactly one of its keys is pressed, saturating at both ends.
    function automatic logic [10:0] axis_move(input logic [10:0] pos, input logic inc,
                                              input logic dec, input logic [11:0] step,
                                              input logic [11:0] lim);
        logic [11:0] p;
        logic [11:0] sum;
        p   = {1'b0, pos};
        sum = p + step;
        axis_move = pos;
        if (inc && !dec)
            axis_move = (sum > lim) ? lim[10:0] : sum[10:0];
        else if (dec && !inc)
            axis_move = (p < step) ? 11'd0 : 11'(p - step);
    endfunction

    logic [2:0]  vs_q;
    logic [3:0]  key_s1_q, key_s2_q;
    logic [3:0]  key_snap_q, key_snap_d;
    logic        en0_q, en0_d, en1_q, en1_d, fast_q, fast_d;
    logic [1:0]  state_q, state_d;
    logic [10:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic        overrun_q, overrun_d;
    logic        fs;
    logic [11:0] step;
    logic        unused_sw;

    assign unused_sw = ^{bus.sw_i[8:3], bus.sw_i[0]};
    assign fs        = vs_q[1] & ~vs_q[2];
    assign step      = fast_q ? STEP_F : STEP_S;

    always_comb begin
        state_d    = state_q;
        key_snap_d = key_snap_q;
        en0_d      = en0_q;
        en1_d      = en1_q;
        fast_d     = fast_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        overrun_d  = overrun_q | (fs && state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (fs) begin
                state_d    = S_UPD0;
                key_snap_d = key_s2_q;
                en0_d      = bus.sw_i[1];
                en1_d      = bus.sw_i[2];
                fast_d     = bus.sw_i[9];
            end
            S_UPD0: begin
                state_d = S_UPD1;
                if (en0_q) begin
                    x0_d = axis_move(x0_q, ~key_snap_q[0], ~key_snap_q[3], step, X_MAX0);
                    y0_d = axis_move(y0_q, ~key_snap_q[1], ~key_snap_q[2], step, Y_MAX0);
                end
            end
            S_UPD1: begin
                state_d = S_DONE;
                if (en1_q) begin
                    x1_d = axis_move(x1_q, ~key_snap_q[0], ~key_snap_q[3], step, X_MAX1);
                    y1_d = axis_move(y1_q, ~key_snap_q[1], ~key_snap_q[2], step, Y_MAX1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_q       <= 3'b000;
            key_s1_q   <= 4'hF;
            key_s2_q   <= 4'hF;
            key_snap_q <= 4'hF;
            en0_q      <= 1'b0;
            en1_q      <= 1'b0;
            fast_q     <= 1'b0;
            state_q    <= S_IDLE;
            x0_q       <= 11'd0;
            y0_q       <= 11'd0;
            x1_q       <= X_MAX1[10:0];
            y1_q       <= Y_MAX1[10:0];
            overrun_q  <= 1'b0;
        end else begin
            vs_q       <= {vs_q[1:0], bus.v_sync_i};
            key_s1_q   <= bus.key_i;
            key_s2_q   <= key_s1_q;
            key_snap_q <= key_snap_d;
            en0_q      <= en0_d;
            en1_q      <= en1_d;
            fast_q     <= fast_d;
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.xpos_0_o     = x0_q;
    assign bus.ypos_0_o     = y0_q;
    assign bus.xpos_1_o     = x1_q;
    assign bus.ypos_1_o     = y1_q;
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.frame_done_o = (state_q == S_DONE);
    assign bus.overrun_o    = overrun_q;
endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// Bench for vga_sprite_scheduler: vector table, hand-built corner sequences,
// and random frames checked against a clamped-arithmetic position model.
module tb_vga_sprite_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_sprite_scheduler_if bus ();
    vga_sprite_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int mx0, my0, mx1, my1;

    typedef struct {
        logic [3:0] key;
        logic [9:0] sw;
        int x0, y0, x1, y1;
    } vec_t;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int mv(input int p, input bit inc, input bit dec, input int st, input int lim);
        if (inc && !dec) return (p + st > lim) ? lim : p + st;
        if (dec && !inc) return (p - st < 0) ? 0 : p - st;
        return p;
    endfunction

    function automatic void model_reset();
        mx0 = 0; my0 = 0; mx1 = 640 - 40; my1 = 480 - 40;
    endfunction

    function automatic void model_frame(input logic [3:0] key, input logic [9:0] sw);
        int st;
        st = sw[9] ? 6 : 2;
        if (sw[1]) begin
            mx0 = mv(mx0, !key[0], !key[3], st, 600);
            my0 = mv(my0, !key[1], !key[2], st, 440);
        end
        if (sw[2]) begin
            mx1 = mv(mx1, !key[0], !key[3], st, 600);
            my1 = mv(my1, !key[1], !key[2], st, 440);
        end
    endfunction

    task automatic chk_pos(input string nm);
        chk({nm, " x0"}, 32'(bus.xpos_0_o), mx0);
        chk({nm, " y0"}, 32'(bus.ypos_0_o), my0);
        chk({nm, " x1"}, 32'(bus.xpos_1_o), mx1);
        chk({nm, " y1"}, 32'(bus.ypos_1_o), my1);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " x0"}, 32'(bus.xpos_0_o), 0);
        chk({nm, " y0"}, 32'(bus.ypos_0_o), 0);
        chk({nm, " x1"}, 32'(bus.xpos_1_o), 600);
        chk({nm, " y1"}, 32'(bus.ypos_1_o), 440);
        chk({nm, " busy"}, 32'(bus.busy_o), 0);
        chk({nm, " frame_done"}, 32'(bus.frame_done_o), 0);
        chk({nm, " overrun"}, 32'(bus.overrun_o), 0);
    endtask

    // One clean frame with edge-exact checks; v_sync goes high just after an edge, so edge N is next.
    task automatic run_frame(input logic [3:0] key, input logic [9:0] sw);
        int ox1, oy1;
        ox1 = mx1; oy1 = my1;
        model_frame(key, sw);
        bus.key_i = key; bus.sw_i = sw; bus.v_sync_i = 1'b1;
        tick(); tick(); tick();
        chk("busy@N+2", 32'(bus.busy_o), 1);
        chk("fd@N+2", 32'(bus.frame_done_o), 0);
        tick();
        chk("x0@N+3", 32'(bus.xpos_0_o), mx0);
        chk("y0@N+3", 32'(bus.ypos_0_o), my0);
        chk("x1 hold@N+3", 32'(bus.xpos_1_o), ox1);
        chk("y1 hold@N+3", 32'(bus.ypos_1_o), oy1);
        tick();
        chk("x1@N+4", 32'(bus.xpos_1_o), mx1);
        chk("y1@N+4", 32'(bus.ypos_1_o), my1);
        chk("fd@N+4", 32'(bus.frame_done_o), 1);
        tick();
        chk("fd@N+5", 32'(bus.frame_done_o), 0);
        chk("busy@N+5", 32'(bus.busy_o), 0);
        bus.v_sync_i = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        int pulses;
        logic [3:0] rk;
        logic [9:0] rs;

        vecs[0] = '{4'hE, 10'h002, 2, 0, 600, 440};
        vecs[1] = '{4'hD, 10'h204, 2, 0, 600, 440};
        vecs[2] = '{4'hB, 10'h204, 2, 0, 600, 434};
        vecs[3] = '{4'hB, 10'h204, 2, 0, 600, 428};
        vecs[4] = '{4'hE, 10'h002, 4, 0, 600, 428};
        vecs[5] = '{4'h7, 10'h202, 0, 0, 600, 428};
        vecs[6] = '{4'h6, 10'h002, 0, 0, 600, 428};
        vecs[7] = '{4'h0, 10'h000, 0, 0, 600, 428};
        vecs[8] = '{4'hC, 10'h006, 2, 2, 600, 430};
        vecs[9] = '{4'hE, 10'h1F9, 2, 2, 600, 430};

        bus.v_sync_i = 1'b0; bus.key_i = 4'hF; bus.sw_i = '0;
        rst = 1'b0;
        tick(); tick();
        chk_reset_state("reset");
        rst = 1'b1;
        model_reset();
        tick(); tick();

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].key, vecs[i].sw);
            chk($sformatf("vec%0d x0", i), 32'(bus.xpos_0_o), vecs[i].x0);
            chk($sformatf("vec%0d y0", i), 32'(bus.ypos_0_o), vecs[i].y0);
            chk($sformatf("vec%0d x1", i), 32'(bus.xpos_1_o), vecs[i].x1);
            chk($sformatf("vec%0d y1", i), 32'(bus.ypos_1_o), vecs[i].y1);
        end

        // v_sync held high: one update only
        pulses = 0;
        model_frame(4'hE, 10'h002);
        bus.key_i = 4'hE; bus.sw_i = 10'h002; bus.v_sync_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.frame_done_o) pulses++;
        end
        chk("held vsync pulses", 32'(pulses), 1);
        chk_pos("held vsync");
        bus.v_sync_i = 1'b0;
        tick(); tick(); tick();

        // Two rising edges two cycles apart: second is ignored and flagged
        pulses = 0;
        model_frame(4'hE, 10'h002);
        bus.key_i = 4'hE; bus.sw_i = 10'h002; bus.v_sync_i = 1'b1;
        tick();
        bus.v_sync_i = 1'b0;
        tick();
        bus.v_sync_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.frame_done_o) pulses++;
        end
        chk("overrun pulses", 32'(pulses), 1);
        chk("overrun set", 32'(bus.overrun_o), 1);
        chk("overrun busy", 32'(bus.busy_o), 0);
        chk_pos("overrun");
        bus.v_sync_i = 1'b0;
        tick(); tick(); tick();
        run_frame(4'hC, 10'h006);
        chk("overrun sticky", 32'(bus.overrun_o), 1);

        for (int i = 0; i < 40; i++) begin
            rk = 4'($urandom_range(0, 15));
            rs = 10'($urandom_range(0, 1023));
            run_frame(rk, rs);
            chk_pos($sformatf("rand%0d", i));
        end

        // Reset lands right after box 0 is written: box 1 must not move
        model_frame(4'hB, 10'h006);
        bus.key_i = 4'hB; bus.sw_i = 10'h006; bus.v_sync_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("midrst x0@N+3", 32'(bus.xpos_0_o), mx0);
        chk("midrst y0@N+3", 32'(bus.ypos_0_o), my0);
        rst = 1'b0;
        tick();
        chk_reset_state("midrst");
        bus.v_sync_i = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) tick();
        chk_reset_state("after midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
